// File: rtl/shift_register.sv
// shift_register: N-bit parallel-load bidirectional shift register; define SHIFT_REGISTER_ROTATE_EN for rotate fill instead of zero fill
module shift_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         dir,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] q
);
  logic fill_l, fill_r;
`ifdef SHIFT_REGISTER_ROTATE_EN
  assign fill_l = q[N-1];
  assign fill_r = q[0];
`else
  assign fill_l = 1'b0;
  assign fill_r = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (load) q <= data_in;
    else if (shift) q <= dir ? {fill_r, q[N-1:1]} : {q[N-2:0], fill_l};
  end
endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed vector table plus randomized run against an arithmetic reference model
module tb_shift_register;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, shift = 1'b0, dir = 1'b0;
  logic [N-1:0] data_in = '0;
  logic [N-1:0] q;
  int tests = 0, fails = 0;
  typedef struct {
    logic r, l, s, d;
    logic [N-1:0] din, exp;
  } vec_t;
  vec_t tv[$];
  logic [N-1:0] m;
  shift_register #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .dir(dir), .data_in(data_in), .q(q)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, l, s, d, input logic [N-1:0] din);
    rst = r;
    load = l;
    shift = s;
    dir = d;
    data_in = din;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [N-1:0] exp);
    tests++;
    if (q !== exp) begin
      fails++;
      $display("FAIL %s: q=%b expected %b", name, q, exp);
    end
  endtask
  function automatic logic [N-1:0] model_shift(input logic [N-1:0] v, input logic d);
`ifdef SHIFT_REGISTER_ROTATE_EN
    return d ? ((v >> 1) | (v << (N - 1))) : ((v << 1) | (v >> (N - 1)));
`else
    return d ? (v >> 1) : (v << 1);
`endif
  endfunction
  initial begin
    tv.push_back('{1, 1, 0, 0, 8'hFF, 8'h00});
    tv.push_back('{0, 1, 0, 0, 8'hEA, 8'hEA});
`ifdef SHIFT_REGISTER_ROTATE_EN
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hD5});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hAB});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h57});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hAE});
    tv.push_back('{0, 0, 0, 0, 8'h00, 8'hAE});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h57});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'hAB});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'hD5});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'hEA});
    tv.push_back('{0, 1, 1, 1, 8'h5A, 8'h5A});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hB4});
    tv.push_back('{1, 0, 1, 0, 8'h00, 8'h00});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h00});
    tv.push_back('{0, 1, 0, 0, 8'h81, 8'h81});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'hC0});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h81});
`else
    tv.push_back('{0, 0, 0, 0, 8'h00, 8'hEA});
    tv.push_back('{0, 0, 0, 1, 8'h33, 8'hEA});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hD4});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hA8});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h50});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'hA0});
    tv.push_back('{0, 0, 0, 0, 8'h00, 8'hA0});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h50});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h28});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h14});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h0A});
    tv.push_back('{0, 1, 1, 1, 8'h5A, 8'h5A});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h2D});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h5A});
    tv.push_back('{1, 0, 1, 0, 8'h00, 8'h00});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h00});
    tv.push_back('{0, 0, 1, 0, 8'h00, 8'h00});
    tv.push_back('{0, 1, 0, 0, 8'hFF, 8'hFF});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h7F});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h3F});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h1F});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h0F});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h07});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h03});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h01});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h00});
    tv.push_back('{0, 0, 1, 1, 8'h00, 8'h00});
`endif
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].l, tv[i].s, tv[i].d, tv[i].din);
      check($sformatf("vec%0d", i), tv[i].exp);
    end
    // hand sequence: N same-direction shifts from a full word
    step(0, 1, 0, 0, 8'hFF);
    m = 8'hFF;
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, 0, 8'h00);
      m = model_shift(m, 1'b0);
    end
`ifdef SHIFT_REGISTER_ROTATE_EN
    check("n_left_restore", 8'hFF);
`else
    check("n_left_zero", 8'h00);
`endif
    for (int i = 0; i < 400; i++) begin
      logic r, l, s, d;
      logic [N-1:0] din;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 4) == 0);
      s = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      din = N'($urandom);
      step(r, l, s, d, din);
      m = r ? '0 : l ? din : s ? model_shift(m, d) : m;
      check($sformatf("rand%0d", i), m);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
